// File: rtl/serial_add_pkg.sv
// +--------------------------------------------------------------------+
// | serial_add_pkg: shared types and helpers for the bit-serial adder  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic s;
    logic c;
  } ha_t;

  // Counter must hold 0..WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic ha_t half_add(input logic x, input logic y);
    ha_t r;
    r.s = x ^ y;
    r.c = x & y;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// +--------------------------------------------------------------------+
// | fa_cell: 1-bit full adder from two half-add stages plus OR         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fa_cell
  import serial_add_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  ha_t ha1;
  ha_t ha2;

  always_comb begin
    ha1 = half_add(a, b);
    ha2 = half_add(ha1.s, ci);
    s   = ha2.s;
    co  = ha1.c | ha2.c;
  end

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// +--------------------------------------------------------------------+
// | serial_add_ctrl: LSB-first bit-serial adder, one shared FA cell    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam int               SR_W     = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [SR_W-1:0]  s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic             fa_s;
  logic             fa_co;
  logic [SR_W-1:0]  s_sr_shift;
  logic [WIDTH-1:0] sum_full;

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // The last sum bit never lands in the shift register; it goes straight
  // into the result alongside the WIDTH-1 bits collected so far.
  generate
    if (WIDTH == 1) begin : g_sr_w1
      assign s_sr_shift = s_sr_q;
      assign sum_full   = fa_s;
    end else if (WIDTH == 2) begin : g_sr_w2
      assign s_sr_shift = fa_s;
      assign sum_full   = {fa_s, s_sr_q};
    end else begin : g_sr_wn
      assign s_sr_shift = {fa_s, s_sr_q[SR_W-1:1]};
      assign sum_full   = {fa_s, s_sr_q};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      s_sr_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      s_sr_q      <= s_sr_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    s_sr_d      = s_sr_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          s_sr_d  = '0;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_sr_shift;
        carry_d = fa_co;
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          sum_d       = sum_full;
          cout_d      = fa_co;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_serial_add_ctrl: scoreboard bench for the bit-serial adder      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  logic         in_valid_1;
  logic         in_ready_1;
  logic [0:0]   a_1;
  logic [0:0]   b_1;
  logic         cin_1;
  logic         out_valid_1;
  logic         out_ready_1;
  logic [0:0]   sum_1;
  logic         cout_1;
  logic         busy_1;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  logic [W:0]   sb_q[$];
  int           lat_q[$];
  logic         prev_ov = 1'b0;
  bit           rnd_stall = 1'b0;
  logic         or_force  = 1'b1;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_1),
    .in_ready  (in_ready_1),
    .a         (a_1),
    .b         (b_1),
    .cin       (cin_1),
    .out_valid (out_valid_1),
    .out_ready (out_ready_1),
    .sum       (sum_1),
    .cout      (cout_1),
    .busy      (busy_1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : or_force;
  end

  // Scoreboard: push at accept, pop and compare at the result handshake.
  always @(negedge clk) begin
    logic [W:0] exp_v;
    if (rst_n === 1'b1) begin
      if (in_valid && in_ready) begin
        chk("accept_not_busy", busy, 0);
        sb_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        lat_q.push_back(cyc);
      end
      if (out_valid && !prev_ov && lat_q.size() > 0)
        chk("latency", cyc - lat_q[0], W + 1);
      if (out_valid && out_ready) begin
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          exp_v = sb_q.pop_front();
          chk("result", {cout, sum}, exp_v);
          void'(lat_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    bit got = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", got, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && in_ready) break;
    end
    chk("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] v1;
    logic [1:0] exp2;
    int         n;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    in_valid_1  = 1'b0;
    a_1         = '0;
    b_1         = '0;
    cin_1       = 1'b0;
    out_ready_1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic adds, including overflow into cout.
    drive_op(8'h0F, 8'h01, 1'b0);
    wait_drain();
    chk("t1_sum", sum, 8'h10);
    chk("t1_cout", cout, 0);
    drive_op(8'hFF, 8'h01, 1'b0);
    drive_op(8'hFF, 8'hFF, 1'b1);
    wait_drain();
    chk("t2_sum", sum, 8'hFF);
    chk("t2_cout", cout, 1);

    // Consumer stall in DONE.
    or_force = 1'b0;
    drive_op(8'hA5, 8'h7C, 1'b1);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk("t3_reach_done", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_sum", sum, 8'h22);
      chk("t3_hold_cout", cout, 1);
      chk("t3_hold_in_ready", in_ready, 0);
    end
    or_force = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("t3_idle_in_ready", in_ready, 1);
    chk("t3_idle_out_valid", out_valid, 0);
    chk("t3_idle_busy", busy, 0);

    // Operands wiggling with in_valid high while RUN must be ignored.
    drive_op(8'h11, 8'h22, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      chk("t4_in_ready_busy", in_ready, 0);
      @(posedge clk);
      #1;
    end
    drive_op(8'h40, 8'h50, 1'b1);
    wait_drain();
    chk("t4_second_sum", sum, 8'h91);

    // Abort by reset at RUN cycle 3.
    drive_op(8'hC3, 8'h5A, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_sum", sum, 0);
    chk("t5_rst_cout", cout, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    sb_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t5_no_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    drive_op(8'h12, 8'h34, 1'b0);
    wait_drain();
    chk("t5_sum", sum, 8'h46);
    chk("t5_cout", cout, 0);

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      v1         = 3'(i);
      exp2       = {1'b0, v1[2]} + {1'b0, v1[1]} + {1'b0, v1[0]};
      a_1        = v1[2];
      b_1        = v1[1];
      cin_1      = v1[0];
      in_valid_1 = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (in_ready_1) break;
      end
      @(posedge clk);
      #1;
      in_valid_1 = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        n++;
        if (out_valid_1) break;
      end
      chk("w1_latency", n, 2);
      chk("w1_result", {cout_1, sum_1}, exp2);
      @(posedge clk);
      #1;
    end

    // Random back-to-back traffic with random consumer stalls.
    rnd_stall = 1'b1;
    for (int i = 0; i < 1000; i++)
      drive_op(8'($urandom), 8'($urandom), 1'($urandom));
    rnd_stall = 1'b0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
